// File: rtl/nor_unit.sv
// Registered WIDTH-bit logic unit: seven bitwise ops plus a multi-beat accumulating NOR.
// Optional `NOR_UNIT_REDUCE_EN adds a registered reduction-NOR of the result on z_red.
module nor_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             z_red,
  output logic             abort
);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] acc_r, acc_nxt_s;
  logic [WIDTH-1:0] z_r, z_nxt_s;
  logic             out_valid_r, out_valid_nxt_s;
  logic             abort_r, abort_nxt_s;
  logic             load_s;
  logic             accept_s;

  function automatic logic [WIDTH-1:0] bit_op(input logic [2:0] sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = ~(x & y);
      3'd3:    r = ~(x | y);
      3'd4:    r = x ^ y;
      3'd5:    r = ~(x ^ y);
      3'd6:    r = ~x;
      default: r = ~(x | y);
    endcase
    return r;
  endfunction

  assign in_ready = ~out_valid_r | out_ready;
  assign accept_s = in_valid & in_ready;

  // Next-state, accumulator and result selection for one accepted beat
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    z_nxt_s     = z_r;
    load_s      = 1'b0;
    abort_nxt_s = 1'b0;
    if (accept_s) begin
      if (op == 3'd7) begin
        case (state_r)
          IDLE: begin
            if (last) begin
              z_nxt_s = ~(a | b);
              load_s  = 1'b1;
            end else begin
              acc_nxt_s   = a | b;
              state_nxt_s = ACC;
            end
          end
          ACC: begin
            if (last) begin
              z_nxt_s     = ~(acc_r | a | b);
              load_s      = 1'b1;
              acc_nxt_s   = {WIDTH{1'b0}};
              state_nxt_s = IDLE;
            end else begin
              acc_nxt_s = acc_r | a | b;
            end
          end
          default: begin
            acc_nxt_s   = {WIDTH{1'b0}};
            state_nxt_s = IDLE;
          end
        endcase
      end else begin
        z_nxt_s = bit_op(op, a, b);
        load_s  = 1'b1;
        // A plain op arriving mid-sequence abandons the partial accumulation
        if (state_r == ACC) begin
          abort_nxt_s = 1'b1;
          acc_nxt_s   = {WIDTH{1'b0}};
          state_nxt_s = IDLE;
        end else begin
          abort_nxt_s = 1'b0;
        end
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output valid: a new load wins over a drain in the same cycle
  always_comb begin
    out_valid_nxt_s = out_valid_r;
    if (load_s) begin
      out_valid_nxt_s = 1'b1;
    end else if (out_valid_r & out_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // State, accumulator and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {WIDTH{1'b0}};
      z_r         <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      abort_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      z_r         <= z_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      abort_r     <= abort_nxt_s;
    end
  end

`ifdef NOR_UNIT_REDUCE_EN
  function automatic logic nor_reduce(input logic [WIDTH-1:0] v);
    return ~|v;
  endfunction

  logic z_red_r;

  // Reduction NOR captured together with each new result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_red_r <= 1'b0;
    end else if (load_s) begin
      z_red_r <= nor_reduce(z_nxt_s);
    end else begin
      z_red_r <= z_red_r;
    end
  end

  assign z_red = z_red_r;
`else
  assign z_red = 1'b0;
`endif

  assign z         = z_r;
  assign out_valid = out_valid_r;
  assign abort     = abort_r;

endmodule

// File: doc/nor_unit.md
# nor_unit

Parametrised, registered bitwise logic unit that generalises the single two-input NOR gate to WIDTH-bit operands, eight selectable operations and a multi-beat accumulating NOR. Operands arrive on a valid/ready input stream; results leave on a registered valid/ready output stream with one-cycle latency. It sits between operand-producing datapath logic and any consumer needing gated or reduced bit vectors.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat this cycle
- op  input  3  operation: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 ACC_NOR
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored for op 6)
- last  input  1  final beat of an ACC_NOR sequence (ignored for other ops)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- z  output  WIDTH  registered result
- z_red  output  1  reduction NOR of z (see Configuration)
- abort  output  1  one-cycle pulse: ACC_NOR sequence abandoned

## Operation
- Accept = in_valid & in_ready; in_ready = ~out_valid | out_ready (combinational, all ops).
- Ops 0–6 on accept: z <= f(a,b), out_valid <= 1.
- FSM states: IDLE, ACC. Internal acc register, WIDTH bits.
- IDLE, op 7, last=0: acc <= a | b; go to ACC; no output.
- IDLE, op 7, last=1: z <= ~(a | b); out_valid <= 1; stay IDLE (single-beat ACC_NOR equals op 3).
- ACC, op 7, last=0: acc <= acc | a | b; stay ACC.
- ACC, op 7, last=1: z <= ~(acc | a | b); out_valid <= 1; acc <= 0; go IDLE.
- ACC, op 0–6 accepted: abort pulses 1 for one cycle, acc <= 0, go IDLE; the beat itself is processed normally.
- Output handshake: out_valid falls when out_valid & out_ready and no new result is loaded that cycle; simultaneous drain and load keeps out_valid=1 with new z.
- z and z_red held stable while out_valid & ~out_ready.
- No beat accepted in a cycle: state, acc, z unchanged.

## Timing
- Reset values: out_valid 0, z 0, z_red 0, abort 0, acc 0, state IDLE; in_ready 1 while rst deasserted after reset.
- Latency: accepted result beat at edge N → out_valid=1, z valid after edge N.
- Throughput: one beat per cycle when out_ready=1.
- ACC_NOR over K beats produces exactly one output, one cycle after the last=1 beat.
- Reset asserted mid-ACC: acc cleared, IDLE, pending output discarded, no abort pulse.
- abort is registered, asserted the cycle after the aborting accept.

## Configuration
- NOR_UNIT_REDUCE_EN defined: z_red registered alongside z, equal to ~|(next z), valid with out_valid.
- Not defined: z_red tied to 0; no reduction logic.

## Test plan
- WIDTH=8, op=3, a=0x0F, b=0x30, out_ready=1 → next cycle out_valid=1, z=0xC0.
- op=4 a=0xAA b=0x0F accepted, out_ready=0 → in_ready=0, z=0xA5 held 3 cycles; second beat waits; out_ready=1 → second result loaded same edge, out_valid stays 1.
- op=7 beats (0x01,0x02,last0),(0x10,0x00,last0),(0x00,0x80,last1) → exactly one output z=0x6C, one cycle after third beat.
- op=7 (0xFF,0x00,last0) then op=0 a=0xF0 b=0x3C → abort pulse one cycle, z=0x30; then op=7 (0x00,0x00,last1) → z=0xFF (acc cleared).
- op=7 (0x0F,0x00,last0), rst pulse mid-sequence → all outputs 0; then op=7 (0x00,0x01,last1) → z=0xFE.
- With NOR_UNIT_REDUCE_EN: op=3 a=0xFF b=0x00 → z=0x00, z_red=1; op=1 a=0x01 b=0x00 → z_red=0; without macro z_red=0 always.
